// File: rtl/dmem_pkg.sv
// dmem_pkg: state encoding, RISC-V funct3 size codes and byte-lane count shared by the
// data-memory controller and its alignment logic.
package dmem_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int LANES = 4;
endpackage

// File: rtl/dmem_align.sv
// dmem_align: byte-lane steering for stores, extraction and sign/zero extension for loads,
// and the misaligned / illegal-funct3 flag.
module dmem_align
  import dmem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        illegal_o
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  assign lane_b = rdata_i[{off_i, 3'b000} +: 8];
  assign lane_h = rdata_i[{off_i[1], 4'b0000} +: 16];
  always_comb begin
    be_o = !we_i ? {LANES{1'b1}} :
           funct3_i[1:0] == 2'b00 ? 4'b0001 << off_i :
           funct3_i[1:0] == 2'b01 ? 4'b0011 << off_i : {LANES{1'b1}};
    wdata_o = funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
              funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    load_o = funct3_i == F3_B  ? {{24{lane_b[7]}}, lane_b} :
             funct3_i == F3_H  ? {{16{lane_h[15]}}, lane_h} :
             funct3_i == F3_BU ? {24'b0, lane_b} :
             funct3_i == F3_HU ? {16'b0, lane_h} : rdata_i;
    // funct3 011/110/111 are undefined; stores only exist as B/H/W
    illegal_o = (&funct3_i[1:0]) | (funct3_i[2] & funct3_i[1]) | (we_i & funct3_i[2]) |
                (funct3_i[1:0] == 2'b01 & off_i[0]) | (funct3_i[1:0] == 2'b10 & |off_i);
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: turns the MEM-stage load/store into the proc_req/mem_rdy/valid memory handshake
// and stalls the pipeline until done. Define DMEM_TIMEOUT_EN to abort loads stuck in WAIT.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [2:0]       funct3_i,
  input  logic [NBITS-1:0] addr_i,
  input  logic [NBITS-1:0] wdata_i,
  input  logic             flush_i,
  input  logic             mem_rdy,
  input  logic             valid,
  input  logic [NBITS-1:0] rdata,
  output logic             proc_req,
  output logic             we_out,
  output logic [NBITS-1:0] addr,
  output logic [NBITS-1:0] wdata,
  output logic [3:0]       be,
  output logic [NBITS-1:0] data_o,
  output logic             done,
  output logic             err,
  output logic             stall
);
  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [3:0]       be_q, be_d, al_be;
  logic [2:0]       f3_q, f3_d;
  logic             we_q, we_d, err_q, err_d, idle, expired, al_illegal;
  logic [31:0]      al_wdata, al_load;
  assign idle = state_q == IDLE;
  // Live operands are steered while accepting; latched ones while extracting the load.
  dmem_align u_align (
    .we_i      (idle ? we_i : we_q),
    .funct3_i  (idle ? funct3_i : f3_q),
    .off_i     (idle ? addr_i[1:0] : addr_q[1:0]),
    .wdata_i   (wdata_i),
    .rdata_i   (rdata),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .load_o    (al_load),
    .illegal_o (al_illegal)
  );
`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt_q;
  assign expired = cnt_q == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= state_q == WAIT ? cnt_q + 1'b1 : '0;
`else
  localparam int unused_timeout = TIMEOUT;
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    we_d    = we_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (req_i) begin
        state_d = al_illegal ? RESP : ISSUE;
        err_d   = al_illegal;
        if (!al_illegal) begin
          addr_d  = addr_i;
          wdata_d = al_wdata;
          be_d    = al_be;
          f3_d    = funct3_i;
          we_d    = we_i;
        end
      end
      ISSUE: state_d = mem_rdy ? (we_q ? RESP : WAIT) : flush_i ? IDLE : ISSUE;
      WAIT: begin
        data_d  = valid ? al_load : data_q;
        err_d   = ~valid & expired;
        state_d = valid | expired ? RESP : WAIT;
      end
      default: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  assign proc_req = state_q == ISSUE;
  assign we_out   = proc_req & we_q;
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign be       = be_q;
  assign data_o   = data_q;
  assign done     = state_q == RESP;
  assign err      = err_q;
  assign stall    = req_i & ~done;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized and directed checks of dmem_ctrl against a byte-arithmetic model
// of store steering, load extension, legality and handshake latency.
module tb_dmem_ctrl;
  localparam int TO = 16;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_i = 1'b0, we_i = 1'b0, flush_i = 1'b0, mem_rdy = 1'b0, valid = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0, rdata = '0;
  logic        proc_req, we_out, done, err, stall;
  logic [31:0] addr, wdata, data_o;
  logic [3:0]  be;
  int vectors = 0, miscompares = 0;
  int obs_done_cyc, obs_stall_cnt;
  logic obs_err, obs_req, obs_we, obs_aborted;
  logic [31:0] obs_addr, obs_wdata, obs_data, last_load;
  logic [3:0] obs_be;

  always #5 clk = ~clk;

  dmem_ctrl #(.NBITS(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .flush_i(flush_i), .mem_rdy(mem_rdy), .valid(valid), .rdata(rdata),
    .proc_req(proc_req), .we_out(we_out), .addr(addr), .wdata(wdata), .be(be),
    .data_o(data_o), .done(done), .err(err), .stall(stall)
  );

  function automatic int nbytes(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic exp_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    return f3 == 3'd3 || f3 >= 3'd6 || (we && f3 >= 3'd3) || (a % nbytes(f3) != 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!we) return 4'hF;
    return 4'(((1 << nbytes(f3)) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (nbytes(f3) == 1) return {24'b0, wd[7:0]} * 32'h01010101;
    if (nbytes(f3) == 2) return {16'b0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int bits;
    logic [31:0] v, m;
    bits = 8 * nbytes(f3);
    if (bits == 32) return w;
    v = w >> (8 * (a % 4));
    m = (32'd1 << bits) - 1;
    v = v & m;
    if (!f3[2] && v[bits-1]) v = v | ~m;
    return v;
  endfunction

  // Acts as the memory for one access; entered and left one time unit after a rising edge.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a, wd,
                            input int rdy_dly, val_dly, input logic [31:0] rword, input int flush_at);
    int ic, wc;
    logic acc, fl, rdy_now;
    obs_done_cyc = -1; obs_stall_cnt = 0; obs_req = 0; obs_aborted = 0; obs_err = 0;
    ic = 0; wc = 0; acc = 0;
    req_i = 1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
    for (int k = 0; k < 64; k++) begin
      fl = 0;
      if (proc_req) begin
        mem_rdy = ic >= rdy_dly;
        fl = ic == flush_at;
        ic++;
        valid = 1'($urandom_range(0, 1));
        rdata = $urandom;
      end else if (acc) begin
        mem_rdy = 1'($urandom_range(0, 1));
        fl = 1'($urandom_range(0, 1));
        valid = wc == val_dly;
        rdata = valid ? rword : $urandom;
        wc++;
      end else begin
        mem_rdy = 1'($urandom_range(0, 1));
        valid = 1'($urandom_range(0, 1));
        rdata = $urandom;
      end
      flush_i = fl;
      rdy_now = proc_req & mem_rdy;
      @(negedge clk);
      if (stall === 1'b1) obs_stall_cnt++;
      if (proc_req) begin
        obs_req = 1; obs_we = we_out; obs_addr = addr; obs_wdata = wdata; obs_be = be;
      end
      if (done) begin
        obs_done_cyc = k; obs_err = err; obs_data = data_o;
      end
      @(posedge clk); #1;
      if (obs_done_cyc >= 0) break;
      if (rdy_now) acc = 1;
      if (fl && !acc) begin
        obs_aborted = 1; req_i = 0;
        break;
      end
    end
    flush_i = 0; valid = 0; mem_rdy = 0;
  endtask

  task automatic test_reset;
    #3 rst = 0; req_i = 1;
    #9;
    vectors++;
    if ({proc_req, we_out, addr, wdata, be, data_o, done, err} !== '0) begin
      miscompares++; $display("FAIL reset_outputs got %0h want 0", {proc_req, we_out, addr, wdata, be, data_o, done, err});
    end
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL reset_stall_hi got %b want 1", stall); end
    req_i = 0; #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall_lo got %b want 0", stall); end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    last_load = 0;
  endtask

  task automatic test_store_sw;
    run_access(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, -1);
    vectors++;
    if (obs_done_cyc !== 2) begin miscompares++; $display("FAIL sw_latency got %0d want 2", obs_done_cyc); end
    vectors++;
    if ({obs_we, obs_addr, obs_be, obs_wdata, obs_err} !== {1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0}) begin
      miscompares++; $display("FAIL sw_bus got %0h want %0h", {obs_we, obs_addr, obs_be, obs_wdata, obs_err}, {1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0});
    end
    vectors++;
    if (obs_stall_cnt !== 2) begin miscompares++; $display("FAIL sw_stall_cycles got %0d want 2", obs_stall_cnt); end
    req_i = 0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL sw_done_pulse got %b want 0", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_lanes;
    run_access(1, 3'b000, 32'h103, 32'h000000A5, 2, 0, 0, -1);
    vectors++;
    if ({obs_done_cyc, obs_we, obs_be, obs_wdata} !== {32'd4, 1'b1, 4'b1000, 32'hA5A5A5A5}) begin
      miscompares++; $display("FAIL sb_bus got cyc=%0d we=%b be=%b wd=%h want cyc=4 we=1 be=1000 wd=a5a5a5a5", obs_done_cyc, obs_we, obs_be, obs_wdata);
    end
    run_access(1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 0, -1);
    vectors++;
    if ({obs_be, obs_wdata} !== {4'b1100, 32'hABCDABCD}) begin
      miscompares++; $display("FAIL sh_bus got be=%b wd=%h want be=1100 wd=abcdabcd", obs_be, obs_wdata);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s  [3] = '{3'b000, 3'b100, 3'b001};
    logic [31:0] want [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00001280};
    for (int i = 0; i < 3; i++) begin
      run_access(0, f3s[i], 32'h102, 32'h0, 0, 1, 32'h1280FF00, -1);
      vectors++;
      if ({obs_done_cyc, obs_data, obs_err} !== {32'd4, want[i], 1'b0}) begin
        miscompares++; $display("FAIL load_f3_%0d got cyc=%0d data=%h err=%b want cyc=4 data=%h err=0", f3s[i], obs_done_cyc, obs_data, obs_err, want[i]);
      end
      vectors++;
      if ({obs_we, obs_be} !== {1'b0, 4'hF}) begin
        miscompares++; $display("FAIL load_bus_%0d got we=%b be=%b want we=0 be=1111", i, obs_we, obs_be);
      end
    end
    last_load = 32'h00001280;
  endtask

  task automatic test_illegal;
    logic        wes [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b100, 3'b011, 3'b110};
    logic [31:0] as  [5] = '{32'h101, 32'h103, 32'h100, 32'h0, 32'h4};
    for (int i = 0; i < 5; i++) begin
      run_access(wes[i], f3s[i], as[i], 32'h55, 0, 0, 32'hFFFFFFFF, -1);
      vectors++;
      if ({obs_req, obs_done_cyc, obs_err, obs_data} !== {1'b0, 32'd1, 1'b1, last_load}) begin
        miscompares++; $display("FAIL illegal_%0d got req=%b cyc=%0d err=%b data=%h want req=0 cyc=1 err=1 data=%h", i, obs_req, obs_done_cyc, obs_err, obs_data, last_load);
      end
    end
  endtask

  task automatic test_flush;
    logic bad = 0;
    run_access(0, 3'b010, 32'h40, 32'h0, 5, 0, 32'h0, 3);
    vectors++;
    if ({obs_aborted, obs_done_cyc} !== {1'b1, -32'sd1}) begin
      miscompares++; $display("FAIL flush_abort got aborted=%b cyc=%0d want aborted=1 cyc=-1", obs_aborted, obs_done_cyc);
    end
    repeat (3) begin
      if (proc_req | done) bad = 1;
      @(posedge clk); #1;
    end
    vectors++;
    if (bad !== 1'b0) begin miscompares++; $display("FAIL flush_quiet got %b want 0", bad); end
    run_access(0, 3'b000, 32'h41, 32'h0, 2, 1, 32'h00007F00, 2);
    vectors++;
    if ({obs_done_cyc, obs_data, obs_err} !== {32'd6, 32'h7F, 1'b0}) begin
      miscompares++; $display("FAIL flush_with_rdy got cyc=%0d data=%h err=%b want cyc=6 data=7f err=0", obs_done_cyc, obs_data, obs_err);
    end
    last_load = 32'h7F;
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout;
    run_access(0, 3'b010, 32'h80, 32'h0, 0, 1000, 32'h0, -1);
    vectors++;
    if ({obs_done_cyc, obs_err, obs_data} !== {32'(2 + TO), 1'b1, last_load}) begin
      miscompares++; $display("FAIL timeout got cyc=%0d err=%b data=%h want cyc=%0d err=1 data=%h", obs_done_cyc, obs_err, obs_data, 2 + TO, last_load);
    end
  endtask
`endif

  task automatic test_reset_mid;
    logic bad;
    req_i = 1; we_i = 0; funct3_i = 3'b010; addr_i = 32'h200; mem_rdy = 0; valid = 0; flush_i = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (proc_req !== 1'b1) begin miscompares++; $display("FAIL rst_issue_req got %b want 1", proc_req); end
    #2 rst = 0; #1;
    vectors++;
    if ({proc_req, done, data_o} !== '0) begin
      miscompares++; $display("FAIL rst_issue_drop got %h want 0", {proc_req, done, data_o});
    end
    req_i = 0; valid = 1; rdata = $urandom;
    @(negedge clk); rst = 1;
    bad = 0;
    repeat (4) begin @(negedge clk); if (done | proc_req) bad = 1; end
    vectors++;
    if (bad !== 1'b0) begin miscompares++; $display("FAIL rst_issue_late_valid got %b want 0", bad); end
    @(posedge clk); #1;
    valid = 0; req_i = 1; funct3_i = 3'b000; addr_i = 32'h301; mem_rdy = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_rdy = 0;
    vectors++;
    if ({proc_req, done, stall} !== 3'b001) begin
      miscompares++; $display("FAIL rst_wait_state got %b want 001", {proc_req, done, stall});
    end
    #2 rst = 0; #1;
    req_i = 0; valid = 1; rdata = 32'hFFFFFFFF;
    @(negedge clk); rst = 1;
    bad = 0;
    repeat (4) begin @(negedge clk); if (done | proc_req | (data_o != 0)) bad = 1; end
    vectors++;
    if (bad !== 1'b0) begin miscompares++; $display("FAIL rst_wait_late_valid got %b want 0", bad); end
    @(posedge clk); #1;
    valid = 0;
    last_load = 0;
  endtask

  task automatic test_random_back_to_back;
    logic [2:0] good_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] bad_f3  [3] = '{3'b011, 3'b110, 3'b111};
    logic we, il;
    logic [2:0] f3;
    logic [31:0] a, wd, rw;
    int rd, vd, want_cyc;
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = $urandom_range(0, 7) == 0 ? bad_f3[$urandom_range(0, 2)] : good_f3[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~32'(nbytes(f3) - 1);
      wd = $urandom; rw = $urandom;
      rd = $urandom_range(0, 3); vd = $urandom_range(0, 3);
      il = exp_illegal(we, f3, a);
      want_cyc = il ? 1 : we ? rd + 2 : rd + vd + 3;
      run_access(we, f3, a, wd, rd, vd, rw, -1);
      if (!il && !we) last_load = exp_load(f3, a, rw);
      vectors++;
      if ({obs_done_cyc, obs_stall_cnt, obs_err, obs_req} !== {want_cyc, want_cyc, il, !il}) begin
        miscompares++; $display("FAIL rnd_%0d_handshake got cyc=%0d stalls=%0d err=%b req=%b want cyc=%0d stalls=%0d err=%b req=%b", n, obs_done_cyc, obs_stall_cnt, obs_err, obs_req, want_cyc, want_cyc, il, !il);
      end
      vectors++;
      if (!il && {obs_we, obs_addr, obs_be} !== {we, a, exp_be(we, f3, a)}) begin
        miscompares++; $display("FAIL rnd_%0d_bus got we=%b addr=%h be=%b want we=%b addr=%h be=%b", n, obs_we, obs_addr, obs_be, we, a, exp_be(we, f3, a));
      end
      vectors++;
      if (!il && we && obs_wdata !== exp_wdata(f3, wd)) begin
        miscompares++; $display("FAIL rnd_%0d_wdata got %h want %h", n, obs_wdata, exp_wdata(f3, wd));
      end
      vectors++;
      if (obs_data !== last_load) begin
        miscompares++; $display("FAIL rnd_%0d_data got %h want %h (f3=%b addr=%h word=%h)", n, obs_data, last_load, f3, a, rw);
      end
      repeat ($urandom_range(0, 2)) begin
        req_i = 0;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset;
    test_store_sw;
    test_store_lanes;
    test_loads;
    test_illegal;
    test_flush;
`ifdef DMEM_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid;
    test_random_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory controller directly downstream of the MEM stage; turns the stage's load/store request into the data-memory proc_req/mem_rdy/valid handshake.
- Store path: generates byte enables and lane-replicated write data.
- Load path: extracts the addressed byte/half/word and sign- or zero-extends it.
- Holds the pipeline with stall until the access completes.

Parameters:
NBITS, 32, data/address width; only 32 is supported (byte-lane logic is fixed at 4 lanes).
TIMEOUT, 16, max cycles in WAIT before abort; used only when DMEM_TIMEOUT_EN is defined.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
req_i  in  1  MEM stage holds a load/store; held stable with all operands while stall=1.
we_i  in  1  1=store, 0=load.
funct3_i  in  3  RISC-V size/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU.
addr_i  in  NBITS  byte address (ALU result).
wdata_i  in  NBITS  store operand (rs2).
flush_i  in  1  branch-taken flush from the pipeline.
mem_rdy  in  1  memory accepts the request this cycle.
valid  in  1  memory read data valid.
rdata  in  NBITS  raw memory word.
proc_req  out  1  request to memory.
we_out  out  1  write enable to memory.
addr  out  NBITS  latched byte address.
wdata  out  NBITS  lane-replicated store data.
be  out  4  byte enables.
data_o  out  NBITS  aligned, extended load result; held until the next load completes.
done  out  1  one-cycle pulse: access complete.
err  out  1  misaligned or illegal funct3 (plus timeout, see below); valid with done.
stall  out  1  combinational: req_i & ~done.

Behaviour:
Reset (rst=0, async):
- state=IDLE; all outputs 0 except stall, which follows req_i.

FSM states IDLE, ISSUE, WAIT, RESP:
- IDLE, req_i=1, access legal: latch addr, we, wdata, be, funct3 → ISSUE.
- IDLE, req_i=1, access illegal (H with addr[0]=1, W with addr[1:0]≠0, funct3 ∈ {011, 110, 111}, or store funct3 ≥ 011): no memory request; err=1 → RESP.
- ISSUE: proc_req=1, we_out=latched we.
  - mem_rdy=1 and store → RESP.
  - mem_rdy=1 and load → WAIT.
  - flush_i=1 with mem_rdy=0 → IDLE: abort, no done, proc_req drops next cycle.
  - flush_i=1 coincident with mem_rdy=1: the access is accepted and completes normally.
- WAIT: proc_req=0.
  - valid=1 → register the extracted/extended load into data_o → RESP.
  - flush_i is ignored once the request has been accepted.
  - mem_rdy is ignored.
- RESP: done=1 for exactly one cycle; err held valid; → IDLE.
  - The MEM stage advances on done; req_i in the following cycle belongs to the next instruction.

Handshake rules:
- valid seen in IDLE or ISSUE is ignored.
- A reset mid-access drops proc_req immediately; a late valid after reset is ignored.

Minimum latency (done high in cycle n):
- store: 2 cycles after req_i (IDLE, ISSUE+rdy, RESP).
- load: 3 cycles (IDLE, ISSUE+rdy, WAIT+valid, RESP).
- illegal: 1 cycle (IDLE, RESP).
- stall is high during every cycle before done.

Store alignment (o = addr[1:0]):
- SB: be=4'b0001<<o, wdata={4{wdata_i[7:0]}}.
- SH: be=4'b0011<<o, wdata={2{wdata_i[15:0]}}.
- SW: be=4'b1111, wdata=wdata_i.
- Load cycles drive be=4'b1111.

Load extraction:
- Byte = rdata[8*o +: 8]; half = rdata[16*o[1] +: 16].
- B/H: sign-extend; BU/HU: zero-extend; W: pass through.

Optional Feature:
DMEM_TIMEOUT_EN:
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle without valid. When it reaches TIMEOUT-1 the FSM goes WAIT→RESP with err=1; data_o is unchanged.
- Undefined: no counter; WAIT waits indefinitely; the TIMEOUT parameter is unused.

Decomposition:
Package dmem_pkg:
- state enum (IDLE/ISSUE/WAIT/RESP).
- funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- lane-count constant.

Sub-module dmem_align (combinational): funct3 + offset + data → be / replicated wdata / extracted load, plus the illegal flag. dmem_ctrl holds the FSM, registers and the optional counter.

Test Plan:
- SW addr=0x100, wdata_i=0xDEADBEEF, mem_rdy=1 in ISSUE → be=1111, wdata=0xDEADBEEF, done in cycle 2, stall high cycles 0-1.
- SB addr=0x103, wdata_i=0x000000A5 → be=1000, wdata=0xA5A5A5A5, we_out=1.
- LB addr=0x102, rdata=0x1280FF00, valid 2 cycles after accept → data_o=0xFFFFFF80; LBU same address → 0x00000080; LH addr=0x102 → 0x00001280.
- LW addr=0x101 → no proc_req, done at cycle 1, err=1.
- Load, mem_rdy held low 3 cycles, flush_i=1 in ISSUE → proc_req falls, no done, FSM returns to IDLE.
- DMEM_TIMEOUT_EN, TIMEOUT=16, load accepted, valid never asserted → done and err=1 after 16 WAIT cycles; rst=0 mid-WAIT → proc_req=0, done=0, IDLE.
